// File: rtl/xmem_arbiter.sv
// Multi-port arbiter and controller for one asynchronous SRAM-style bus.
// Per-port requests are latched, granted one at a time, and sequenced as a read or a write cycle.
module xmem_arbiter #(
  parameter int NPORTS      = 4,
  parameter int AW          = 23,
  parameter int DW          = 16,
  parameter int BEW         = DW / 8,
  parameter int RD_WAIT     = 1,
  parameter int WR_PULSE    = 1,
  parameter int ROUND_ROBIN = 1,
  localparam int GW         = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req_rd,
  input  logic [NPORTS-1:0]     req_wr,
  input  logic [NPORTS*AW-1:0]  req_addr,
  input  logic [NPORTS*DW-1:0]  req_wdata,
  input  logic [NPORTS*BEW-1:0] req_be_n,
  output logic [NPORTS-1:0]     rd_ack,
  output logic [NPORTS-1:0]     wr_ack,
  output logic [DW-1:0]         rdata,
  output logic [AW-1:0]         SRAM_ADR,
  output logic [BEW-1:0]        SRAM_BE,
  output logic [DW-1:0]         SRAM_DAT_out,
  input  logic [DW-1:0]         SRAM_DAT_in,
  output logic                  SRAM_DAT_drive,
  output logic                  SRAM_CE,
  output logic                  SRAM_OE,
  output logic                  SRAM_WE,
  output logic                  addr_strobe,
  input  logic                  memory_busy,
  input  logic                  use_memory_busy,
  output logic [GW-1:0]         grant_id
);

  localparam int CW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_SAMP, S_WR_SETUP, S_WR_PULSE, S_WR_END, S_GRACE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NPORTS-1:0]    rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [NPORTS-1:0]    clr_rd, clr_wr;
  logic [NPORTS-1:0]    rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic [GW-1:0]        last_q, last_d, grant_q, grant_d;
  logic                 ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic                 drive_q, drive_d, strobe_q, strobe_d;
  logic [DW-1:0]        rdata_q, rdata_d, dout_q, dout_d;
  logic [AW-1:0]        adr_q, adr_d;
  logic [BEW-1:0]       be_q, be_d;

  logic [AW-1:0]        addr_arr  [NPORTS];
  logic [DW-1:0]        wdata_arr [NPORTS];
  logic [BEW-1:0]       be_arr    [NPORTS];

  logic [NPORTS-1:0]    rd_live, wr_live, any_req;
  logic                 found;
  logic [GW-1:0]        pick, cand;
  logic                 busy;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    assign be_arr[gi]    = req_be_n[gi*BEW +: BEW];
  end

  // Live pulses take part in arbitration so an idle bus grants in the request cycle.
  assign rd_live = rd_pend_q | req_rd;
  assign wr_live = wr_pend_q | req_wr;
  assign any_req = rd_live | wr_live;
  assign busy    = use_memory_busy & memory_busy;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (ROUND_ROBIN != 0) cand = GW'((int'(last_q) + 1 + k) % NPORTS);
      else                  cand = GW'(k);
      if (!found && any_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    ce_d     = ce_q;
    oe_d     = oe_q;
    we_d     = we_q;
    drive_d  = drive_q;
    strobe_d = 1'b0;
    rd_ack_d = '0;
    wr_ack_d = '0;
    rdata_d  = rdata_q;
    dout_d   = dout_q;
    adr_d    = adr_q;
    be_d     = be_q;
    clr_rd   = '0;
    clr_wr   = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = pick;
          last_d   = pick;
          adr_d    = addr_arr[pick];
          be_d     = be_arr[pick];
          strobe_d = 1'b1;
          ce_d     = 1'b0;
          if (rd_live[pick]) begin
            clr_rd[pick] = 1'b1;
            oe_d         = 1'b0;
            cnt_d        = CW'(RD_WAIT);
            state_d      = S_RD;
          end else begin
            clr_wr[pick] = 1'b1;
            dout_d       = wdata_arr[pick];
            drive_d      = 1'b1;
            state_d      = S_WR_SETUP;
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) state_d = S_RD_SAMP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RD_SAMP: begin
        if (!busy) begin
          rdata_d           = SRAM_DAT_in;
          ce_d              = 1'b1;
          oe_d              = 1'b1;
          rd_ack_d[grant_q] = 1'b1;
          state_d           = S_IDLE;
        end
      end
      S_WR_SETUP: begin
        we_d    = 1'b0;
        cnt_d   = CW'(WR_PULSE - 1);
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!busy) begin
          we_d              = 1'b1;
          ce_d              = 1'b1;
          wr_ack_d[grant_q] = 1'b1;
          state_d           = S_WR_END;
        end
      end
      S_WR_END: begin
        // Data stays driven through the ack cycle for hold time.
        drive_d = 1'b0;
        state_d = S_GRACE;
      end
      S_GRACE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A pulse that was itself granted is consumed; a pulse on top of an older pending one re-arms.
  assign rd_pend_d = (rd_pend_q & ~clr_rd) | (req_rd & ~(clr_rd & ~rd_pend_q));
  assign wr_pend_d = (wr_pend_q & ~clr_wr) | (req_wr & ~(clr_wr & ~wr_pend_q));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      last_q    <= GW'(NPORTS - 1);
      grant_q   <= '0;
      ce_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      drive_q   <= 1'b0;
      strobe_q  <= 1'b0;
      rd_ack_q  <= '0;
      wr_ack_q  <= '0;
      rdata_q   <= '0;
      dout_q    <= '0;
      adr_q     <= '0;
      be_q      <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ce_q      <= ce_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      drive_q   <= drive_d;
      strobe_q  <= strobe_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rdata_q   <= rdata_d;
      dout_q    <= dout_d;
      adr_q     <= adr_d;
      be_q      <= be_d;
    end
  end

  assign rd_ack         = rd_ack_q;
  assign wr_ack         = wr_ack_q;
  assign rdata          = rdata_q;
  assign SRAM_ADR       = adr_q;
  assign SRAM_BE        = be_q;
  assign SRAM_DAT_out   = dout_q;
  assign SRAM_DAT_drive = drive_q;
  assign SRAM_CE        = ce_q;
  assign SRAM_OE        = oe_q;
  assign SRAM_WE        = we_q;
  assign addr_strobe    = strobe_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_xmem_arbiter.sv
// Self-checking bench for xmem_arbiter: vector table, scoreboard of acks, and multi-cycle sequences.
module tb_xmem_arbiter;

  localparam int NP = 4;
  localparam int AW = 23;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     req_rd = '0, req_wr = '0, f_req_rd = '0, f_req_wr = '0;
  logic [NP*AW-1:0]  req_addr = '0;
  logic [NP*DW-1:0]  req_wdata = '0;
  logic [NP*2-1:0]   req_be_n = '1;
  logic              memory_busy = 1'b0, use_memory_busy = 1'b0;
  logic              mem_force = 1'b0;
  logic [DW-1:0]     mem_force_val = '0;
  logic [DW-1:0]     SRAM_DAT_in;

  logic [NP-1:0]     rd_ack, wr_ack, f_rd_ack, f_wr_ack;
  logic [DW-1:0]     rdata, SRAM_DAT_out, f_rdata, f_dat_out;
  logic [AW-1:0]     SRAM_ADR, f_adr;
  logic [1:0]        SRAM_BE, f_be, grant_id, f_grant;
  logic              SRAM_DAT_drive, SRAM_CE, SRAM_OE, SRAM_WE, addr_strobe;
  logic              f_drive, f_ce, f_oe, f_we, f_strobe;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_seen = 0;

  always #5 clock = ~clock;

  // Memory model: a fixed pattern of the address, garbage while busy is raised.
  assign SRAM_DAT_in = memory_busy ? 16'hDEAD :
                       (mem_force ? mem_force_val : (SRAM_ADR[15:0] ^ 16'h5A5A));

  xmem_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .RD_WAIT(1), .WR_PULSE(2), .ROUND_ROBIN(1)) u_dut (
    .clock(clock), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be_n(req_be_n), .rd_ack(rd_ack), .wr_ack(wr_ack), .rdata(rdata),
    .SRAM_ADR(SRAM_ADR), .SRAM_BE(SRAM_BE), .SRAM_DAT_out(SRAM_DAT_out), .SRAM_DAT_in(SRAM_DAT_in),
    .SRAM_DAT_drive(SRAM_DAT_drive), .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE), .SRAM_WE(SRAM_WE),
    .addr_strobe(addr_strobe), .memory_busy(memory_busy), .use_memory_busy(use_memory_busy),
    .grant_id(grant_id)
  );

  xmem_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .RD_WAIT(1), .WR_PULSE(2), .ROUND_ROBIN(0)) u_fix (
    .clock(clock), .reset(reset), .req_rd(f_req_rd), .req_wr(f_req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be_n(req_be_n), .rd_ack(f_rd_ack), .wr_ack(f_wr_ack), .rdata(f_rdata),
    .SRAM_ADR(f_adr), .SRAM_BE(f_be), .SRAM_DAT_out(f_dat_out), .SRAM_DAT_in(SRAM_DAT_in),
    .SRAM_DAT_drive(f_drive), .SRAM_CE(f_ce), .SRAM_OE(f_oe), .SRAM_WE(f_we),
    .addr_strobe(f_strobe), .memory_busy(memory_busy), .use_memory_busy(use_memory_busy),
    .grant_id(f_grant)
  );

  typedef struct {
    bit          is_wr;
    int          port;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    bit          is_wr;
    int          port;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be_n;
    bit          qual;
    int          busy;
    int          lat;
    int          we_low;
    logic [15:0] data;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  logic [3:0] mon_oh;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int p, input logic [22:0] a, input logic [15:0] d, input logic [1:0] be);
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_be_n[p*2 +: 2]    = be;
  endtask

  task automatic push(input bit w, input int p, input logic [15:0] d);
    sb_t e;
    e.is_wr = w;
    e.port  = p;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) tick();
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_rd = '0;
    req_wr = '0;
    f_req_rd = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: each ack pops the oldest expected transaction.
  always @(negedge clock) begin
    if (!reset && ((rd_ack | wr_ack) != 4'b0)) begin
      ack_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: rd_ack=%b wr_ack=%b, required none", rd_ack, wr_ack);
      end else begin
        mon_e  = sb.pop_front();
        mon_oh = 4'b0001 << mon_e.port;
        check("ack_vector", {rd_ack, wr_ack}, mon_e.is_wr ? {4'b0000, mon_oh} : {mon_oh, 4'b0000});
        check("ack_data", mon_e.is_wr ? SRAM_DAT_out : rdata, mon_e.data);
        $display("ack %s port %0d data %h (expected port %0d data %h)",
                 mon_e.is_wr ? "wr" : "rd", mon_e.port, mon_e.is_wr ? SRAM_DAT_out : rdata,
                 mon_e.port, mon_e.data);
      end
    end
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   cyc, we_low, base, fp;
    bit   got;
    int   exp_fix[5];

    tbl[0] = '{0, 0, 23'h000100, 16'h0000, 2'b00, 0, 0, 4, 0, 16'h5B5A};
    tbl[1] = '{0, 3, 23'h7FFFFF, 16'h0000, 2'b00, 1, 0, 4, 0, 16'hA5A5};
    tbl[2] = '{0, 2, 23'h000000, 16'h0000, 2'b10, 1, 5, 9, 0, 16'h5A5A};
    tbl[3] = '{0, 1, 23'h012345, 16'h0000, 2'b00, 0, 3, 4, 0, 16'hDEAD};
    tbl[4] = '{1, 3, 23'h400000, 16'hABCD, 2'b00, 0, 0, 4, 2, 16'hABCD};
    tbl[5] = '{1, 2, 23'h000FFF, 16'h5555, 2'b10, 1, 2, 6, 4, 16'h5555};
    tbl[6] = '{1, 1, 23'h000010, 16'h00FF, 2'b11, 0, 1, 4, 2, 16'h00FF};
    tbl[7] = '{0, 0, 23'h00ABCD, 16'h0000, 2'b01, 1, 1, 5, 0, 16'hF197};
    exp_fix = '{0, 0, 0, 0, 3};

    // Reset values
    tick();
    tick();
    check("rst_strobes", {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_DAT_drive, addr_strobe}, 5'b11100);
    check("rst_be", SRAM_BE, 2'b11);
    check("rst_acks", {rd_ack, wr_ack}, 8'h00);
    check("rst_data", {rdata, SRAM_DAT_out}, 32'h0);
    check("rst_adr_grant", {SRAM_ADR, grant_id}, 25'h0);
    reset = 1'b0;

    // Single read, port 1
    set_port(1, 23'h002000, 16'h0000, 2'b00);
    mem_force = 1'b1;
    mem_force_val = 16'hBEEF;
    req_rd[1] = 1'b1;
    push(0, 1, 16'hBEEF);
    tick();
    req_rd = '0;
    check("rd_c1_ce_oe_strobe", {SRAM_CE, SRAM_OE, addr_strobe}, 3'b001);
    check("rd_c1_adr_grant", {SRAM_ADR, grant_id}, {23'h002000, 2'd1});
    tick();
    check("rd_c2", {SRAM_CE, SRAM_OE, addr_strobe, rd_ack}, 7'b0000000);
    tick();
    check("rd_c3", {SRAM_CE, SRAM_OE, rd_ack, wr_ack}, 10'b0);
    tick();
    check("rd_c4_ack", {rd_ack, wr_ack}, 8'b0010_0000);
    check("rd_c4_data_strobes", {rdata, SRAM_CE, SRAM_OE}, {16'hBEEF, 2'b11});
    tick();
    check("rd_c5_hold", {rd_ack, rdata}, {4'b0, 16'hBEEF});
    mem_force = 1'b0;

    // Single write, port 0
    set_port(0, 23'h000040, 16'h1234, 2'b01);
    req_wr[0] = 1'b1;
    push(1, 0, 16'h1234);
    tick();
    req_wr = '0;
    check("wr_c1", {SRAM_WE, SRAM_CE, SRAM_DAT_drive, addr_strobe}, 4'b1011);
    check("wr_c1_be_dat", {SRAM_BE, SRAM_DAT_out}, {2'b01, 16'h1234});
    tick();
    check("wr_c2", {SRAM_WE, SRAM_DAT_drive}, 2'b01);
    tick();
    check("wr_c3", {SRAM_WE, wr_ack}, 5'b0_0000);
    tick();
    check("wr_c4", {SRAM_WE, SRAM_CE, SRAM_DAT_drive, wr_ack}, 7'b111_0001);
    tick();
    check("wr_grace", {SRAM_WE, SRAM_CE, SRAM_DAT_drive, wr_ack}, 7'b110_0000);
    tick();

    // Vector table: latency, WE width, address/byte-enable issue, busy handling
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      set_port(v.port, v.addr, v.wdata, v.be_n);
      use_memory_busy = v.qual;
      if (v.is_wr) req_wr[v.port] = 1'b1;
      else         req_rd[v.port] = 1'b1;
      push(v.is_wr, v.port, v.data);
      cyc = 0;
      we_low = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
        tick();
        cyc++;
        req_rd = '0;
        req_wr = '0;
        memory_busy = (cyc >= 3) && (cyc < 3 + v.busy);
        if (cyc == 1) begin
          check($sformatf("vec%0d_issue", i), {SRAM_ADR, SRAM_BE, grant_id, addr_strobe},
                {v.addr, v.be_n, 2'(v.port), 1'b1});
        end
        if (!SRAM_WE) we_low++;
        if ((rd_ack | wr_ack) != 4'b0) got = 1'b1;
      end
      memory_busy = 1'b0;
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(v.lat));
      check($sformatf("vec%0d_we_low", i), 64'(we_low), 64'(v.we_low));
      tick();
      tick();
      tick();
    end
    use_memory_busy = 1'b0;
    drain("table_drain", 10);

    // Round-robin: all four at once, port 0 re-requests after its ack
    do_reset();
    for (int p = 0; p < 4; p++) begin
      set_port(p, 23'(32'h000300 + p), 16'h0000, 2'b00);
      push(0, p, 16'(32'h0300 + p) ^ 16'h5A5A);
    end
    push(0, 0, 16'h0300 ^ 16'h5A5A);
    req_rd = 4'b1111;
    tick();
    req_rd = '0;
    for (int c = 0; c < 20 && rd_ack[0] == 1'b0; c++) tick();
    check("rr_first_ack", rd_ack, 4'b0001);
    tick();
    req_rd[0] = 1'b1;
    tick();
    req_rd = '0;
    drain("rr_drain", 60);

    // Write pulsed in the same cycle as the previous read ack on the same port
    base = ack_seen;
    set_port(2, 23'h000222, 16'h0000, 2'b00);
    push(0, 2, 16'h0222 ^ 16'h5A5A);
    req_rd[2] = 1'b1;
    tick();
    req_rd = '0;
    for (int c = 0; c < 20 && rd_ack[2] == 1'b0; c++) tick();
    check("b2b_rd_ack", rd_ack, 4'b0100);
    set_port(2, 23'h000223, 16'hCAFE, 2'b00);
    req_wr[2] = 1'b1;
    push(1, 2, 16'hCAFE);
    tick();
    req_wr = '0;
    check("b2b_wr_grant", {addr_strobe, grant_id, SRAM_WE, SRAM_DAT_drive, SRAM_ADR},
          {1'b1, 2'd2, 1'b1, 1'b1, 23'h000223});
    drain("b2b_drain", 20);
    repeat (10) tick();
    check("b2b_ack_count", 64'(ack_seen - base), 64'd2);

    // Reset during the write pulse; a pending read on port 3 must be lost
    set_port(1, 23'h000555, 16'h7777, 2'b00);
    req_wr[1] = 1'b1;
    tick();
    req_wr = '0;
    set_port(3, 23'h000666, 16'h0000, 2'b00);
    req_rd[3] = 1'b1;
    tick();
    req_rd = '0;
    check("rst_mid_we_low", SRAM_WE, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_mid_strobes", {SRAM_WE, SRAM_CE, SRAM_OE, SRAM_DAT_drive, wr_ack}, 8'b1110_0000);
    reset = 1'b0;
    base = ack_seen;
    repeat (12) tick();
    check("rst_mid_no_ack", 64'(ack_seen - base), 64'd0);
    push(0, 3, 16'h0666 ^ 16'h5A5A);
    req_rd[3] = 1'b1;
    tick();
    req_rd = '0;
    drain("post_reset_read", 20);

    // Fixed priority: port 0 keeps re-requesting and starves port 3
    do_reset();
    f_req_rd = 4'b1001;
    tick();
    f_req_rd = '0;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 30 && f_rd_ack == 4'b0; c++) tick();
      fp = 7;
      for (int b = 0; b < 4; b++) if (f_rd_ack[b]) fp = b;
      check($sformatf("fixed_order%0d", n), 64'(fp), 64'(exp_fix[n]));
      $display("fixed ack %0d port %0d (expected %0d)", n, fp, exp_fix[n]);
      if (n < 3 && fp == 0) f_req_rd[0] = 1'b1;
      tick();
      f_req_rd = '0;
    end

    repeat (5) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xmem_arbiter.md
# xmem_arbiter

Parametrised external-memory controller and arbiter for the EP994A/icy99 memory subsystem. It serialises NPORTS independent requestors (CPU, VDP, loaders, etc.) onto one asynchronous SRAM-style bus. Arbitration is fixed-priority or round-robin. Read wait states and write pulse width are configurable, and the memory_busy stall is honoured. It generalises the single-purpose SRAM controller by turning per-client hardwired paths into uniform ports.

## Interface

Parameters:
- NPORTS, 4: number of requestor ports (1..8).
- AW, 23: word address width.
- DW, 16: data width; multiple of 8.
- BEW, DW/8: byte-enable width (derived).
- RD_WAIT, 1: cycles CS/OE held before read sample (0..15).
- WR_PULSE, 1: cycles WE held low (1..15).
- ROUND_ROBIN, 1: 1 = rotating priority; 0 = fixed, port 0 highest.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_rd  in  NPORTS  per-port read request pulse.
- req_wr  in  NPORTS  per-port write request pulse.
- req_addr  in  NPORTS*AW  port p at [p*AW +: AW]; held stable until ack.
- req_wdata  in  NPORTS*DW  write data; held stable until ack.
- req_be_n  in  NPORTS*BEW  active-low byte enables; MSB lane is the lowest byte address (big endian).
- rd_ack  out  NPORTS  one-cycle read-done pulse.
- wr_ack  out  NPORTS  one-cycle write-done pulse.
- rdata  out  DW  last read word; valid while rd_ack is high and held until the next read.
- SRAM_ADR  out  AW.
- SRAM_BE  out  BEW  active low.
- SRAM_DAT_out  out  DW.
- SRAM_DAT_in  in  DW.
- SRAM_DAT_drive  out  1.
- SRAM_CE, SRAM_OE, SRAM_WE  out  1 each  active low.
- addr_strobe  out  1  one-cycle pulse when a new address is issued.
- memory_busy  in  1.
- use_memory_busy  in  1  address-decoded qualifier for memory_busy.
- grant_id  out  $clog2(NPORTS) (min 1)  port currently served; debug.

## Operation

- **Pending latches.**
  - A req_rd or req_wr pulse sets that port's pending bit (rd_pend / wr_pend).
  - The pending bit clears when the port is granted.
  - A pulse in the grant cycle re-arms the bit as a new request.
  - If a port has both rd and wr pending, read wins.
- **Arbitration.** Performed only in IDLE, over pending bits OR live pulses.
  - Fixed mode: lowest index wins.
  - Round-robin mode: search starts at last_grant+1 modulo NPORTS.
  - last_grant resets to NPORTS-1, so port 0 wins first.
- **States:** IDLE, RD, RD_SAMP, WR_SETUP, WR_PULSE, WR_END, GRACE.
  - **IDLE → RD:** latch addr and be_n, addr_strobe=1, CE=OE=0. Counter = RD_WAIT.
  - **RD:** decrement the counter. At 0, go to RD_SAMP.
  - **RD_SAMP:** if use_memory_busy && memory_busy, stay. Otherwise: rdata <= SRAM_DAT_in, CE=OE=1, rd_ack[grant]=1, go to IDLE.
  - **IDLE → WR_SETUP:** latch addr, be_n and wdata, addr_strobe=1, CE=0, drive=1, WE=1.
  - **WR_SETUP → WR_PULSE:** WE=0, counter = WR_PULSE-1.
  - **WR_PULSE:** decrement the counter. At 0, if busy is qualified-high, hold. Otherwise go to WR_END.
  - **WR_END:** WE=1, CE=1, wr_ack[grant]=1; drive remains 1 this cycle for hold time. Go to GRACE.
  - **GRACE:** drive=0, all strobes high, go to IDLE.
- SRAM_DAT_out, SRAM_ADR and SRAM_BE are registered and change only when a new transaction is granted.

## Timing

- **Reset values:**
  - SRAM_CE, SRAM_OE, SRAM_WE = 1; SRAM_BE = all 1.
  - SRAM_DAT_drive = 0; addr_strobe = 0.
  - rd_ack, wr_ack = 0; rdata = 0; SRAM_ADR = 0; SRAM_DAT_out = 0; grant_id = 0.
  - All pending bits cleared; state = IDLE.
- **Reset mid-transaction:** strobes deassert on the next edge, no ack is issued, and pending requests are lost.
- **Read** (request in IDLE at cycle 0, busy low):
  - Address/CE/OE are active from cycle 1.
  - Data is sampled at the end of cycle 1+RD_WAIT+1.
  - rd_ack is high in cycle 3+RD_WAIT.
  - With RD_WAIT=1, rd_ack is high in cycle 4.
- **Write** (request in IDLE at cycle 0):
  - WR_SETUP in cycle 1.
  - WE low in cycles 2..1+WR_PULSE.
  - wr_ack is high in cycle 2+WR_PULSE.
  - GRACE follows; the next grant is possible in cycle 4+WR_PULSE.
- Each busy-high cycle in RD_SAMP or the final WR_PULSE cycle adds exactly one cycle.
- Back-to-back reads: the next grant occurs in the cycle after rd_ack, because IDLE evaluates there.
- Requests arriving during a transaction are latched and never dropped.
- Each ack is exactly one cycle, exactly once per request.

## Test plan

- Reset, then a single read on port 1, addr 0x002000, memory returns 0xBEEF, RD_WAIT=1 → CE/OE low cycles 1-3, rd_ack[1] high in cycle 4, rdata = 0xBEEF, no other ack.
- Write on port 0, data 0x1234, be_n 2'b01, WR_PULSE=2 → WE low exactly 2 cycles, SRAM_BE = 01, drive high from cycle 1 through wr_ack cycle, then drive=0 in GRACE.
- Round-robin: ports 0-3 all pulse req_rd in the same cycle → grants in order 0,1,2,3, then port 0 again after a new pulse. With ROUND_ROBIN=0 and port 0 re-requesting each time, port 0 starves port 3 until it stops.
- use_memory_busy=1 with memory_busy high 5 cycles during a read → rd_ack delayed by exactly 5 cycles; data is sampled only after busy falls.
- Port 2 pulses req_wr in the same cycle its previous rd_ack fires → write serviced next; exactly one wr_ack.
- Assert reset during WR_PULSE → WE/CE return high next cycle, no wr_ack, pending bits clear, and a subsequent read completes normally.
